regfile_sb: RTL
===============

# regfile_sb

Parametrised, scoreboarded register file for the pipelined RV32I core. It replaces the fixed 32x32, two-read-port register file. It adds configurable width, depth and read-port count, a per-register pending scoreboard for hazard detection, and a post-reset zeroing sweep. It sits between decode (reads, issue marking) and writeback (single write port).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, >= 4)
- NRD, 2, number of read ports
- AW, $clog2(NREGS), register address width (derived; do not override)

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- we  in  1  writeback enable
- wa  in  AW  writeback register address
- wd  in  XLEN  writeback data
- iss_en  in  1  issue: mark iss_rd pending
- iss_rd  in  AW  destination register of the issued instruction
- ra  in  NRD*AW  read addresses; port i is ra[i*AW +: AW]
- rdata  out  NRD*XLEN  read data; port i is rdata[i*XLEN +: XLEN]
- rpend  out  NRD  1 = register read on port i has an outstanding producer
- ready  out  1  1 = sweep complete, block accepts we/iss_en

## Operation
- Storage array mem[NREGS] is not reset. Zeroing is done by the sweep FSM.
- Scoreboard pend[NREGS] is asynchronously cleared by rst.
- Register 0 reads 0 and is never pending. Writes and issues to 0 are dropped.
- FSM states:
  - INIT: on rst, state=INIT, ptr=1, ready=0. Each edge writes mem[ptr]=0 and increments ptr. At the edge with ptr==NREGS-1, go to RUN.
  - RUN: ready=1. The FSM stays in RUN until rst.
- In INIT:
  - we and iss_en are ignored.
  - All rdata=0 and all rpend=0.
- In RUN, at each edge:
  - If we and wa!=0: mem[wa]<=wd and pend[wa]<=0.
  - If iss_en and iss_rd!=0: pend[iss_rd]<=1.
  - Same register in both: issue wins (pend stays 1, data still written). A new producer supersedes the old one.
- Writes to a non-pending register are legal; the data is written.
- Reads are combinational from ra:
  - rdata[i]=mem[ra[i]]
  - rpend[i]=pend[ra[i]]
  - Both are 0 when ra[i]==0.
- Multiple read ports may address the same register. Each returns an identical result.

## Timing
- Reset values: ready=0, all rpend=0, all rdata=0.
- INIT duration: exactly NREGS-1 rising edges after rst deasserts. ready rises after the last sweep edge (31 edges for the defaults).
- rst asserted mid-operation: the block immediately enters INIT, clears pend and restarts the sweep from ptr=1. Any write in flight is lost.
- Write latency without bypass: data and pend clear are visible on rdata/rpend in the cycle after the write edge.
- Issue latency: pend is visible on rpend in the cycle after the iss_en edge. There is never a same-cycle issue bypass.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, if we, wa!=0 and ra[i]==wa, then rdata[i]=wd in the same cycle.
  - rpend[i]=0 in that case, unless iss_en with iss_rd==wa is also asserted in that cycle.
- REGFILE_BYPASS_EN undefined:
  - No forwarding; reads return the stored value and stored pend.
  - The pipeline must stall one extra cycle on write-then-read.

## Structure
- The shared package holds:
  - the FSM state enum (ST_INIT, ST_RUN)
  - the zero-register address constant
  - default XLEN/NREGS parameters shared with decode and writeback
- One natural sub-module: regfile_scoreboard. It holds the pend vector, the set/clear priority and the per-port rpend lookup. The top level keeps storage, the sweep FSM and the read muxes.

## Test plan
- Reset, then count edges → ready=0 for 31 edges and 1 afterwards. Every register reads 0 and rpend=0.
- In RUN: we=1, wa=5, wd=AAAABBBB, then we=1, wa=10, wd=12345678; read ra0=5, ra1=10 → rdata AAAABBBB / 12345678.
- we=1, wa=0, wd=FFFFFFFF, plus iss_en=1, iss_rd=0 → register 0 reads 0 with rpend=0.
- Scoreboard sequence, each row reading register 7:
  - iss_en iss_rd=7 → rpend=1 on the next cycle.
  - we wa=7 wd=00000042 → rpend=0 and data 42 (same cycle with bypass, next cycle without).
  - Same cycle iss_rd=7 and wa=7 → rpend stays 1.
- With REGFILE_BYPASS_EN: we wa=3 wd=DEADBEEF while ra0=3 → rdata0=DEADBEEF in the same cycle. Without the macro → old value, then DEADBEEF next cycle.
- Mid-run rst pulse after writing register 9 → ready drops, all rpend=0, register 9 reads 0 during and after the sweep, and ready returns after 31 edges.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file, used by decode and writeback.
package regfile_sb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int REG_ZERO      = 0;
    localparam int DEFAULT_XLEN  = 32;
    localparam int DEFAULT_NREGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set on issue, cleared on writeback.
// With REGFILE_BYPASS_EN a same-cycle writeback hides the pending bit it is about to clear.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_idx_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_idx_i,
    input  logic [NRD*AW-1:0] ra_i,
    output logic [NRD-1:0]    rpend_o
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        pend_d = pend_q;
        if (clr_en_i) pend_d[clr_idx_i] = 1'b0;
        if (set_en_i) pend_d[set_idx_i] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_port
        logic [AW-1:0] addr;
        assign addr = ra_i[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign rpend_o[i] = (clr_en_i && clr_idx_i == addr) ? (set_en_i && set_idx_i == addr)
                                                             : pend_q[addr];
`else
        assign rpend_o[i] = pend_q[addr];
`endif
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with scoreboard and post-reset zeroing sweep.
// Optional same-cycle write forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN  = DEFAULT_XLEN,
    parameter  int NREGS = DEFAULT_NREGS,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [AW-1:0]       wa_i,
    input  logic [XLEN-1:0]     wd_i,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic [NRD*AW-1:0]   ra_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    output logic [NRD-1:0]      rpend_o,
    output logic                ready_o
);

    localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
    localparam logic [AW-1:0] LAST_A = AW'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [XLEN-1:0] mem_q [NREGS];
    logic            run;
    logic            wr_en;
    logic            iss_set;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;
    logic [NRD-1:0]  sb_rpend;

    assign run     = (state_q == ST_RUN);
    assign wr_en   = run && we_i && (wa_i != ZERO_A);
    assign iss_set = run && iss_en_i && (iss_rd_i != ZERO_A);

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == LAST_A) state_d = ST_RUN;
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ready_o = (state_q == ST_RUN);
    end

    // The sweep owns the single write port until RUN; writeback is ignored meanwhile.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = ptr_q;
        mem_wd = '0;
        if (!run) begin
            mem_we = 1'b1;
        end else if (wr_en) begin
            mem_we = 1'b1;
            mem_wa = wa_i;
            mem_wd = wd_i;
        end
    end

    // NOTE: storage has no reset; the sweep zeroes it so the array can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        assign addr = ra_i[i*AW +: AW];
        always_comb begin
            data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && wa_i == addr) data = wd_i;
`endif
            if (!run || addr == ZERO_A) data = '0;
        end
        assign rdata_o[i*XLEN +: XLEN] = data;
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en_i  (iss_set),
        .set_idx_i (iss_rd_i),
        .clr_en_i  (wr_en),
        .clr_idx_i (wa_i),
        .ra_i      (ra_i),
        .rpend_o   (sb_rpend)
    );

    assign rpend_o = run ? sb_rpend : '0;

endmodule
